c2h_packetizer: RTL
===================

Name: c2h_packetizer

Overview:
Transmit end of the card-to-host stream. Takes DDR4 read-return beats from the command scheduler's read path, which has no backpressure, and buffers them in a FIFO. Emits them as an AXI4-Stream master toward the DMA S2MM channel, with tkeep and tlast framing in fixed-length packets. Sits inside sddt_core between the read-data path and the M_AXIS_C2H port. Provides an overflow error flag and a handshake counter for the GPIO debug word.

Parameters:
DATA_WIDTH, 512, width of rd_data and M_AXIS_C2H_tdata; must be a multiple of 8
FIFO_DEPTH, 16, buffer entries; power of 2, at least 4
PKT_LEN_WIDTH, 16, width of pkt_len

Ports:
c0_ddr4_clk  in  1  single clock for all logic
c0_ddr4_rst  in  1  reset; synchronous, active-high
rd_data_valid  in  1  one read beat present this cycle; no backpressure
rd_data  in  DATA_WIDTH  read beat
pkt_len  in  PKT_LEN_WIDTH  beats per packet; sampled at the start of each packet
flush  in  1  single-cycle pulse; close the current partial packet
M_AXIS_C2H_tdata  out  DATA_WIDTH  stream data
M_AXIS_C2H_tkeep  out  DATA_WIDTH/8  byte enables
M_AXIS_C2H_tlast  out  1  last beat of packet
M_AXIS_C2H_tvalid  out  1  stream valid
M_AXIS_C2H_tready  in  1  DMA ready
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
handshake_count  out  8  count of tvalid&&tready beats, wraps at 255
err  out  1  sticky overflow flag

Behaviour:
- Clocking and reset
  - One clock domain, c0_ddr4_clk; reset c0_ddr4_rst is synchronous and active-high.
  - Reset values: tvalid=0, tlast=0, tdata=0, tkeep=all-ones, fifo_level=0, handshake_count=0, err=0, FSM=IDLE, beat counter=0, flush_pending=0.
  - Reset mid-packet discards all buffered data and the partial packet. No tlast is emitted for it.
- FIFO write
  - A beat is written when rd_data_valid=1 and the FIFO is not full.
  - "Full" is evaluated after the same-cycle pop: a write at level==FIFO_DEPTH is accepted if the output stage pops that cycle.
  - Otherwise the beat is dropped and err is set to 1. err stays set until reset.
- Output stage
  - The output register holds the current beat. It loads from the FIFO when tvalid=0, or when tvalid&&tready.
  - Latency: a beat written at clock edge e is visible on tdata with tvalid=1 after edge e+1, provided the FIFO and output register were empty and the FSM is in IDLE or STREAM.
  - Once tvalid is asserted, tdata, tlast and tkeep are held until tready.
  - tvalid does not depend combinationally on tready.
  - tkeep is always all-ones.
- FSM
  - IDLE: when the first beat is loaded into the output register, latch plen = (pkt_len==0 ? 1 : pkt_len), set beat counter to 1, go to STREAM.
  - STREAM: each beat loaded increments the beat counter. The beat with counter==plen carries tlast=1.
  - STREAM, on handshake of the tlast beat: go to IDLE. A beat already in the FIFO is loaded the next cycle and starts a new packet (back-to-back packets, no gap beyond one cycle).
  - flush pulse: sets flush_pending.
    - In IDLE with an empty FIFO, flush is a no-op and flush_pending clears.
    - Otherwise, the beat loaded when the FIFO becomes empty carries tlast=1, even if its counter < plen. flush_pending then clears at that beat's handshake.
  - Beats arriving after the flush pulse but before the FIFO drains belong to the flushed packet.
  - Flush and tlast on the same beat (counter==plen at drain): exactly one tlast, no extra beat.
- Counters
  - handshake_count increments on each tvalid&&tready and wraps 255 -> 0.
  - fifo_level is a registered value equal to the FIFO occupancy. It excludes the output register.

Optional Feature:
C2H_ZERO_PAD_EN
- With the macro defined: on flush with a partial packet (counter<plen at drain), the FSM enters PAD. It emits zero-data beats with tkeep all-ones until counter==plen; the final pad beat carries tlast. Incoming rd_data during PAD is still written to the FIFO and starts the next packet after PAD.
- Without the macro: no PAD state. The short packet ends with tlast on the last real beat.

Test Plan:
1. Reset, pkt_len=4, 8 consecutive rd_data_valid beats (data=0..7), tready=1 -> two packets; tlast on data 3 and 7; handshake_count=8; err=0; first tvalid 2 edges after the first write.
2. tready=0; drive 17 beats with FIFO_DEPTH=16 -> 16 buffered plus 1 in the output register; no drop. Drive an 18th beat -> err=1 and beat dropped. Release tready -> 17 beats in order.
3. pkt_len=8, 3 beats then flush pulse -> tlast on the 3rd beat. With C2H_ZERO_PAD_EN: 5 zero beats follow, tlast on the 8th beat.
4. pkt_len=0, 3 beats -> each beat has tlast=1 (three 1-beat packets).
5. Random tready toggling, 100 beats, pkt_len=7 -> data order preserved; tdata stable while tvalid&&!tready; tlast every 7th beat; handshake_count=100.
6. Assert c0_ddr4_rst mid-packet with FIFO level=5 -> next cycle tvalid=0, fifo_level=0, err=0; next packet's tlast timing counts from 1.

Source files
------------

// File: rtl/c2h_packetizer.sv
// rtl/c2h_packetizer.sv - buffers DDR4 read-return beats and emits them as fixed-length AXI4-Stream packets
// Optional: define C2H_ZERO_PAD_EN to zero-pad flushed short packets out to the latched length.
module c2h_packetizer #(
  parameter int DATA_WIDTH    = 512,
  parameter int FIFO_DEPTH    = 16,
  parameter int PKT_LEN_WIDTH = 16
) (
  input  logic                          c0_ddr4_clk,
  input  logic                          c0_ddr4_rst,
  input  logic                          rd_data_valid,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  input  logic [PKT_LEN_WIDTH-1:0]      pkt_len,
  input  logic                          flush,
  output logic [DATA_WIDTH-1:0]         M_AXIS_C2H_tdata,
  output logic [DATA_WIDTH/8-1:0]       M_AXIS_C2H_tkeep,
  output logic                          M_AXIS_C2H_tlast,
  output logic                          M_AXIS_C2H_tvalid,
  input  logic                          M_AXIS_C2H_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    handshake_count,
  output logic                          err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]            DEPTH_C  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]            LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0]          PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [PKT_LEN_WIDTH-1:0] CNT_ONE = {{(PKT_LEN_WIDTH-1){1'b0}}, 1'b1};

`ifdef C2H_ZERO_PAD_EN
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_PAD} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_STREAM} state_t;
`endif

  state_t                    state_q, state_d;
  logic [DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count_q, count_d;
  logic [DATA_WIDTH-1:0]     tdata_q, tdata_d;
  logic                      tlast_q, tlast_d, tvalid_q, tvalid_d;
  logic [PKT_LEN_WIDTH-1:0]  cnt_q, cnt_d, plen_q, plen_d;
  logic                      flush_pending_q, flush_pending_d;
  logic                      flush_last_q, flush_last_d;
  logic [7:0]                hs_cnt_q, hs_cnt_d;
  logic                      err_q, err_d;

  logic                      hs, out_free, pop, push, drain, flush_eff, start, at_len, flush_hit;
  logic [PKT_LEN_WIDTH-1:0]  plen_new, cnt_new;

  assign hs       = tvalid_q && M_AXIS_C2H_tready;
  assign out_free = !tvalid_q || M_AXIS_C2H_tready;
`ifdef C2H_ZERO_PAD_EN
  assign pop      = out_free && (count_q != '0) && (state_q != S_PAD);
`else
  assign pop      = out_free && (count_q != '0);
`endif
  // Full is judged after the same-cycle pop so a full FIFO still accepts while draining.
  assign push     = rd_data_valid && ((count_q != DEPTH_C) || pop);
  assign drain    = (count_q == LVL_ONE) && !push;
  // A flush already honoured by the beat handshaking now must not also close the next packet.
  assign flush_eff = (flush_pending_q && !(hs && flush_last_q)) || flush;
  assign start    = (state_q == S_IDLE) || (hs && tlast_q);
  assign plen_new = start ? ((pkt_len == '0) ? CNT_ONE : pkt_len) : plen_q;
  assign cnt_new  = start ? CNT_ONE : cnt_q + CNT_ONE;
  assign at_len   = (cnt_new == plen_new);
  assign flush_hit = flush_eff && drain;

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    count_d         = count_q;
    tdata_d         = tdata_q;
    tlast_d         = tlast_q;
    tvalid_d        = tvalid_q;
    cnt_d           = cnt_q;
    plen_d          = plen_q;
    flush_pending_d = flush_eff;
    flush_last_d    = flush_last_q;
    hs_cnt_d        = hs_cnt_q;
    err_d           = err_q || (rd_data_valid && !push);

    if (state_q == S_IDLE && count_q == '0) flush_pending_d = 1'b0;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push && !pop)      count_d = count_q + LVL_ONE;
    else if (pop && !push) count_d = count_q - LVL_ONE;

    if (hs) begin
      hs_cnt_d = hs_cnt_q + 8'd1;
      tvalid_d = 1'b0;
      if (tlast_q) state_d = S_IDLE;
    end

    if (pop) begin
      tvalid_d     = 1'b1;
      tdata_d      = mem_q[rd_ptr_q];
      plen_d       = plen_new;
      cnt_d        = cnt_new;
      state_d      = S_STREAM;
      tlast_d      = at_len || flush_hit;
      flush_last_d = flush_hit;
`ifdef C2H_ZERO_PAD_EN
      if (flush_hit && !at_len) begin
        tlast_d         = 1'b0;
        flush_last_d    = 1'b0;
        flush_pending_d = 1'b0;
        state_d         = S_PAD;
      end
`endif
    end

`ifdef C2H_ZERO_PAD_EN
    if (state_q == S_PAD && out_free && !(hs && tlast_q)) begin
      tvalid_d     = 1'b1;
      tdata_d      = '0;
      cnt_d        = cnt_q + CNT_ONE;
      tlast_d      = ((cnt_q + CNT_ONE) == plen_q);
      flush_last_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge c0_ddr4_clk) begin
    if (push) mem_q[wr_ptr_q] <= rd_data;
  end

  always_ff @(posedge c0_ddr4_clk) begin
    if (c0_ddr4_rst) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      tdata_q         <= '0;
      tlast_q         <= 1'b0;
      tvalid_q        <= 1'b0;
      cnt_q           <= '0;
      plen_q          <= CNT_ONE;
      flush_pending_q <= 1'b0;
      flush_last_q    <= 1'b0;
      hs_cnt_q        <= '0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      tdata_q         <= tdata_d;
      tlast_q         <= tlast_d;
      tvalid_q        <= tvalid_d;
      cnt_q           <= cnt_d;
      plen_q          <= plen_d;
      flush_pending_q <= flush_pending_d;
      flush_last_q    <= flush_last_d;
      hs_cnt_q        <= hs_cnt_d;
      err_q           <= err_d;
    end
  end

  assign M_AXIS_C2H_tdata  = tdata_q;
  assign M_AXIS_C2H_tkeep  = '1;
  assign M_AXIS_C2H_tlast  = tlast_q;
  assign M_AXIS_C2H_tvalid = tvalid_q;
  assign fifo_level        = count_q;
  assign handshake_count   = hs_cnt_q;
  assign err               = err_q;
endmodule
